// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/halfword/word accesses to a word-wide data memory.
// Big-endian byte lanes; sub-word stores are done as read-modify-write.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic [31:0] LoadData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrError,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} stateT;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } opT;

  stateT       state, nextState;
  opT          reqOp, opReg;
  logic [31:0] addrReg, storeReg, memWord;
  logic        accept, misaligned, regIsLoad;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue, writeWord;

  assign reqOp     = opT'(Op);
  assign accept    = ((state == IDLE) || (state == DONE)) && Start;
  assign regIsLoad = (opReg inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});

  // Alignment is judged on the live request so a bad access never touches memory.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    misaligned = 1'b0;
    case (reqOp)
      OP_LH, OP_LHU, OP_SH: misaligned = Address[0];
      OP_LW, OP_SW:         misaligned = |Address[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (!Start)                nextState = IDLE;
        else if (misaligned)       nextState = DONE;
        else if (reqOp == OP_SW)   nextState = WRITE;
        else                       nextState = READ;
      end
      READ:    nextState = regIsLoad ? DONE : WRITE;
      WRITE:   nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state only
  always_comb begin
    Busy         = 1'b0;
    Done         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemWriteData = '0;
    case (state)
      READ:  begin Busy = 1'b1; MemRead = 1'b1; end
      WRITE: begin Busy = 1'b1; MemWrite = 1'b1; MemWriteData = writeWord; end
      DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  // Same latched address drives both halves of a read-modify-write.
  assign MemAddress = {2'b00, addrReg[31:2]};

  // Lane extraction: offset 0 is the most significant byte.
  always_comb begin
    loadByte = MemReadData[31:24];
    case (addrReg[1:0])
      2'd0: loadByte = MemReadData[31:24];
      2'd1: loadByte = MemReadData[23:16];
      2'd2: loadByte = MemReadData[15:8];
      2'd3: loadByte = MemReadData[7:0];
      default: ;
    endcase
    loadHalf = addrReg[1] ? MemReadData[15:0] : MemReadData[31:16];
  end

  always_comb begin
    loadValue = MemReadData;
    case (opReg)
      OP_LB:   loadValue = {{24{loadByte[7]}}, loadByte};
      OP_LBU:  loadValue = {24'h0, loadByte};
      OP_LH:   loadValue = {{16{loadHalf[15]}}, loadHalf};
      OP_LHU:  loadValue = {16'h0, loadHalf};
      default: loadValue = MemReadData;
    endcase
  end

  // Store merge: only the addressed lane replaces the captured memory word.
  always_comb begin
    writeWord = memWord;
    case (opReg)
      OP_SB: begin
        case (addrReg[1:0])
          2'd0: writeWord[31:24] = storeReg[7:0];
          2'd1: writeWord[23:16] = storeReg[7:0];
          2'd2: writeWord[15:8]  = storeReg[7:0];
          2'd3: writeWord[7:0]   = storeReg[7:0];
          default: ;
        endcase
      end
      OP_SH: begin
        if (addrReg[1]) writeWord[15:0]  = storeReg[15:0];
        else            writeWord[31:16] = storeReg[15:0];
      end
      OP_SW:   writeWord = storeReg;
      default: ;
    endcase
  end

  // Request latches, captured read word, load result and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: these are plain registers, not a memory array, so clearing them on reset is cheap and expected.
      opReg     <= OP_LB;
      addrReg   <= '0;
      storeReg  <= '0;
      memWord   <= '0;
      LoadData  <= '0;
      AddrError <= 1'b0;
    end else begin
      AddrError <= accept && misaligned;
      if (accept) begin
        opReg    <= reqOp;
        addrReg  <= Address;
        storeReg <= StoreData;
      end
      if (state == READ) begin
        if (regIsLoad) LoadData <= loadValue;
        else           memWord  <= MemReadData;
      end
    end
  end

  a_noReadWrite : assert property (@(posedge clk) disable iff (reset) !(MemRead && MemWrite));
  a_quietWrData : assert property (@(posedge clk) disable iff (reset) MemWrite || (MemWriteData == '0));

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model of expected per-cycle outputs,
// a small word memory, and directed requests with hand-computed literal results.
module tb_load_store_unit;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                         LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] Address, StoreData;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;
  logic        Busy, Done, AddrError, MemRead, MemWrite;

  load_store_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .Address(Address),
    .StoreData(StoreData), .LoadData(LoadData), .Busy(Busy), .Done(Done),
    .AddrError(AddrError), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(int i);
    return (i == 5) ? 32'h8899AABB : (32'hC0DE0000 | 32'(i));
  endfunction

  // Environment memory seen by the DUT
  logic [31:0] ram [64];
  logic        loadRam;
  assign MemReadData = ram[MemAddress[5:0]];
  always @(posedge clk) begin
    if (loadRam) for (int i = 0; i < 64; i++) ram[i] <= initWord(i);
    else if (MemWrite) ram[MemAddress[5:0]] <= MemWriteData;
  end

  int nCmp = 0, nErr = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected behaviour of one clock cycle
  typedef struct packed {
    logic busy, done, rd, wr, err, ldv;
    logic [31:0] wdata, ld, maddr;
  } cycT;

  cycT         cur = '0;
  cycT         pend[$];
  logic [31:0] refMem [64];
  logic [31:0] expLoad = '0;
  bit          modelLive = 0;

  // Model: on each edge, commit the write that was just performed, then either
  // plan a newly accepted request as a list of future cycles or advance one cycle.
  initial forever begin
    @(posedge clk);
    if (cur.wr) refMem[cur.maddr[5:0]] = cur.wdata;
    if (loadRam) for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
    if (reset) begin
      pend.delete();
      cur = '0;
      expLoad = '0;
      modelLive = 1;
    end else begin
      if (!cur.busy && Start) begin
        cycT e;
        logic [31:0] w, b, h, val, mask, ins, maddr;
        int off, sh;
        bit bad;
        maddr = {2'b00, Address[31:2]};
        w   = refMem[maddr[5:0]];
        off = int'(Address[1:0]);
        b   = (w >> (8 * (3 - off))) & 32'hFF;
        h   = (w >> (16 * (1 - int'(Address[1])))) & 32'hFFFF;
        bad = ((Op == LH || Op == LHU || Op == SH) && Address[0]) ||
              ((Op == LW || Op == SW) && Address[1:0] != 2'b00);
        if (bad) begin
          e = '0; e.done = 1; e.err = 1; pend.push_back(e);
        end else if (Op <= LHU) begin
          case (Op)
            LB:      val = 32'($signed(b[7:0]));
            LBU:     val = b;
            LH:      val = 32'($signed(h[15:0]));
            LHU:     val = h;
            default: val = w;
          endcase
          e = '0; e.busy = 1; e.rd = 1; e.maddr = maddr; pend.push_back(e);
          e = '0; e.done = 1; e.ldv = 1; e.ld = val; pend.push_back(e);
        end else if (Op == SW) begin
          e = '0; e.busy = 1; e.wr = 1; e.wdata = StoreData; e.maddr = maddr; pend.push_back(e);
          e = '0; e.done = 1; pend.push_back(e);
        end else begin
          if (Op == SB) begin
            sh = 8 * (3 - off);
            mask = 32'hFF << sh;
            ins  = (StoreData & 32'hFF) << sh;
          end else begin
            sh = 16 * (1 - int'(Address[1]));
            mask = 32'hFFFF << sh;
            ins  = (StoreData & 32'hFFFF) << sh;
          end
          e = '0; e.busy = 1; e.rd = 1; e.maddr = maddr; pend.push_back(e);
          e = '0; e.busy = 1; e.wr = 1; e.wdata = (w & ~mask) | ins; e.maddr = maddr; pend.push_back(e);
          e = '0; e.done = 1; pend.push_back(e);
        end
      end
      if (pend.size() > 0) begin
        cur = pend.pop_front();
        if (cur.ldv) expLoad = cur.ld;
      end else begin
        cur = '0;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  int rdCount = 0, wrCount = 0, doneCount = 0;
  initial forever begin
    @(negedge clk);
    if (MemRead === 1'b1)  rdCount++;
    if (MemWrite === 1'b1) wrCount++;
    if (Done === 1'b1)     doneCount++;
    if (modelLive) begin
      check("Busy", 32'(Busy), 32'(cur.busy));
      check("Done", 32'(Done), 32'(cur.done));
      check("MemRead", 32'(MemRead), 32'(cur.rd));
      check("MemWrite", 32'(MemWrite), 32'(cur.wr));
      check("MemWriteData", MemWriteData, cur.wr ? cur.wdata : 32'h0);
      check("LoadData", LoadData, expLoad);
      if (cur.done) check("AddrError", 32'(AddrError), 32'(cur.err));
      if (cur.rd || cur.wr) check("MemAddress", MemAddress, cur.maddr);
    end
  end

  // Issue one request from IDLE, scramble inputs after acceptance, wait for Done.
  task automatic request(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input int expLat, output logic err);
    int cyc;
    Start = 1'b1; Op = op; Address = addr; StoreData = data;
    @(posedge clk); #2;
    Start = 1'b0; Op = 3'($urandom); Address = $urandom; StoreData = $urandom;
    cyc = 1;
    while (Done !== 1'b1 && cyc < 8) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(expLat));
    err = AddrError;
    @(posedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic err;
    int rd0, wr0, dn0;
    reset = 1'b1; loadRam = 1'b1; Start = 1'b0; Op = '0; Address = '0; StoreData = '0;
    repeat (2) @(posedge clk);
    #2;
    check("reset Busy", 32'(Busy), 32'h0);
    check("reset Done", 32'(Done), 32'h0);
    check("reset LoadData", LoadData, 32'h0);
    check("reset MemWriteData", MemWriteData, 32'h0);
    reset = 1'b0; loadRam = 1'b0;
    @(posedge clk); #2;

    // Loads from word 5 = 8899AABB
    request(LB, 32'h15, 32'h0, 2, err);
    check("LB 0x15", LoadData, 32'hFFFFFF99);
    check("LB err", 32'(err), 32'h0);
    request(LBU, 32'h15, 32'h0, 2, err);
    check("LBU 0x15", LoadData, 32'h00000099);
    request(LH, 32'h14, 32'h0, 2, err);
    check("LH 0x14", LoadData, 32'hFFFF8899);
    request(LHU, 32'h16, 32'h0, 2, err);
    check("LHU 0x16", LoadData, 32'h0000AABB);
    request(LW, 32'h14, 32'h0, 2, err);
    check("LW 0x14", LoadData, 32'h8899AABB);

    // Read-modify-write stores
    request(SH, 32'h16, 32'h00001234, 3, err);
    check("SH ram5", ram[5], 32'h88991234);
    check("SH keeps LoadData", LoadData, 32'h8899AABB);
    request(SB, 32'h15, 32'hFFFFFF77, 3, err);
    check("SB ram5", ram[5], 32'h88771234);
    check("ram5 vs model", ram[5], refMem[5]);

    // Misaligned requests never touch memory
    rd0 = rdCount; wr0 = wrCount;
    request(LW, 32'h6, 32'h0, 1, err);
    check("LW 0x6 err", 32'(err), 32'h1);
    request(SH, 32'h15, 32'hFFFF, 1, err);
    check("SH 0x15 err", 32'(err), 32'h1);
    request(SW, 32'h22, 32'h1, 1, err);
    check("SW 0x22 err", 32'(err), 32'h1);
    request(LHU, 32'h13, 32'h0, 1, err);
    check("LHU 0x13 err", 32'(err), 32'h1);
    check("misaligned reads", 32'(rdCount - rd0), 32'h0);
    check("misaligned writes", 32'(wrCount - wr0), 32'h0);
    check("misaligned LoadData", LoadData, 32'h8899AABB);
    request(LB, 32'h17, 32'h0, 2, err);
    check("LB 0x17", LoadData, 32'h00000034);
    check("LB 0x17 err", 32'(err), 32'h0);

    // SW then LW back-to-back with Start held through DONE
    Start = 1'b1; Op = SW; Address = 32'h20; StoreData = 32'hDEADBEEF;
    @(posedge clk); #2;
    Op = LW; Address = 32'h20; StoreData = 32'h0;
    @(posedge clk); #2;
    check("b2b SW done", 32'(Done), 32'h1);
    @(posedge clk); #2;
    Start = 1'b0;
    check("b2b LW in READ", 32'(MemRead), 32'h1);
    @(posedge clk); #2;
    check("b2b LW done", 32'(Done), 32'h1);
    check("b2b LoadData", LoadData, 32'hDEADBEEF);
    check("b2b ram8", ram[8], 32'hDEADBEEF);
    @(posedge clk); #2;

    // Start pulsed while busy is ignored
    dn0 = doneCount; wr0 = wrCount;
    Start = 1'b1; Op = LB; Address = 32'h15;
    @(posedge clk); #2;
    Op = SW; Address = 32'h0; StoreData = 32'hFFFFFFFF;
    @(posedge clk); #2;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("busy-ignore dones", 32'(doneCount - dn0), 32'h1);
    check("busy-ignore writes", 32'(wrCount - wr0), 32'h0);
    check("busy-ignore LoadData", LoadData, 32'h00000077);

    // Reset during the READ of an SB aborts it
    dn0 = doneCount; wr0 = wrCount;
    Start = 1'b1; Op = SB; Address = 32'h1C; StoreData = 32'hAB;
    @(posedge clk); #2;
    Start = 1'b0; reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    check("abort Busy", 32'(Busy), 32'h0);
    repeat (4) @(posedge clk);
    #2;
    check("abort dones", 32'(doneCount - dn0), 32'h0);
    check("abort writes", 32'(wrCount - wr0), 32'h0);
    check("abort ram7", ram[7], 32'hC0DE0007);
    check("abort LoadData", LoadData, 32'h0);

    request(LW, 32'h1C, 32'h0, 2, err);
    check("LW 0x1C", LoadData, 32'hC0DE0007);
    repeat (3) @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Start  input  1  pipeline request strobe; sampled only in IDLE or DONE.
REQ-004 Op  input  3  access type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-005 Address  input  32  byte address from ALU.
REQ-006 StoreData  input  32  store operand; the low byte or halfword is used for SB or SH.
REQ-007 LoadData  output  32  extended load result; holds its value until the next load completes.
REQ-008 Busy  output  1  high in READ or WRITE states.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 AddrError  output  1  misaligned access flag; valid when Done=1.
REQ-011 MemAddress  output  32  word index to data memory: {2'b00, latched Address[31:2]}.
REQ-012 MemWriteData  output  32  word to be written to memory.
REQ-013 MemRead  output  1  memory read enable.
REQ-014 MemWrite  output  1  memory write enable.
REQ-015 MemReadData  input  32  combinational read word from memory.

Function
REQ-016 The FSM SHALL have states IDLE, READ, WRITE, DONE; MemRead, MemWrite, Busy and Done SHALL be decoded from the registered state only (Moore).
REQ-017 On accepting Start, Op, Address and StoreData SHALL be latched; later input changes SHALL NOT affect the access in progress.
REQ-018 Alignment: LH, LHU and SH SHALL require Address[0]=0; LW and SW SHALL require Address[1:0]=00; byte ops are always aligned.
REQ-019 Misaligned request: IDLE/DONE -> DONE with AddrError=1; MemRead and MemWrite SHALL remain 0.
REQ-020 Aligned load: -> READ (MemRead=1 for exactly one cycle), MemReadData captured at the end of READ, -> DONE with LoadData updated; Done occurs 2 cycles after the Start edge.
REQ-021 SW: -> WRITE (MemWrite=1 for one cycle, MemWriteData=StoreData) -> DONE; Done occurs 2 cycles after the Start edge.
REQ-022 SB/SH (read-modify-write): -> READ, capture word -> WRITE with merged word -> DONE; Done occurs 3 cycles after the Start edge; MemAddress SHALL be identical in READ and WRITE.
REQ-023 Byte lanes SHALL be big-endian: offset 0 = bits [31:24], offset 3 = bits [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
REQ-024 LB/LH SHALL sign-extend to 32 bits; LBU/LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-025 SB/SH merge SHALL replace only the addressed lane; all other bits SHALL keep the captured memory value.
REQ-026 DONE SHALL last exactly one cycle, then go to IDLE, or go directly to READ/WRITE/DONE if Start=1 (back-to-back accepted).
REQ-027 Start asserted while Busy=1 SHALL be ignored; no queuing.
REQ-028 AddrError SHALL be 0 in any DONE cycle not caused by a misaligned request; stores SHALL NOT modify LoadData.
REQ-029 MemWriteData SHALL be 0 whenever MemWrite=0.

Reset
REQ-030 With reset=1 at a rising edge, state SHALL go to IDLE and LoadData, AddrError and latched registers SHALL go to 0; Busy, Done, MemRead and MemWrite SHALL be 0 from that edge on.
REQ-031 Reset SHALL take priority over Start.
REQ-032 Reset in READ or WRITE SHALL abort the access with no Done pulse; reset in READ of an SB/SH SHALL produce no MemWrite.

Verification
REQ-033 Memory word 5 = 32'h8899AABB; LB Address=0x15 -> Done at +2, LoadData=32'hFFFFFF99; LBU same address -> 32'h00000099.
REQ-034 Word 5 = 32'h8899AABB; SH StoreData=32'h00001234, Address=0x16 -> READ then WRITE with MemWriteData=32'h88991234; Done at +3; memory word 5 = 32'h88991234.
REQ-035 LW Address=0x0000_0006 -> Done at +1 with AddrError=1; MemRead and MemWrite stay 0 for the whole sequence; LoadData unchanged.
REQ-036 SW 32'hDEADBEEF to 0x20, Start held high in DONE with LW 0x20 -> the load enters READ without an IDLE cycle; LoadData=32'hDEADBEEF.
REQ-037 SB issued, reset asserted during its READ cycle -> next state IDLE, MemWrite never asserted, no Done pulse, memory unchanged.
REQ-038 Start pulsed while Busy=1 -> no extra access; exactly one Done per accepted request.
